serial_carry_adder: RTL and testbench

//   Bit-serial adder that sits directly upstream of the gated carry-detect

---
 rtl/serial_carry_adder.sv | 152 +++++++++++++++
 tb/tb_serial_carry_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_carry_adder.sv
// ---------------------------------------------------------------------------
// serial_carry_adder
//
// Bit-serial adder. Two WIDTH-bit operands are shifted out LSB-first, one
// bit pair per enabled clock, through a single registered full-adder carry.
// The current bit pair and carry are exposed every RUN cycle for a
// downstream carry-detect stage. The completed sum and carry-out are
// reported with a single-cycle done pulse and held until the next accepted
// start.
//
// Parameters
//   WIDTH     operand / sum width in bits (>= 2)
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   i_start   in   1      request; sampled only in IDLE
//   i_en      in   1      step enable; 0 stalls RUN with everything held
//   i_op_a    in   WIDTH  operand A, captured on accepted start
//   i_op_b    in   WIDTH  operand B, captured on accepted start
//   i_cin     in   1      carry-in, captured on accepted start
//   o_bit_a   out  1      current LSB of the A shift register (0 outside RUN)
//   o_bit_b   out  1      current LSB of the B shift register (0 outside RUN)
//   o_bit_c   out  1      current registered carry (0 outside RUN)
//   o_busy    out  1      high while in RUN
//   o_done    out  1      one-cycle pulse in DONE
//   o_sum     out  WIDTH  result, valid from done until next accepted start
//   o_cout    out  1      final carry-out, same validity as o_sum
// ---------------------------------------------------------------------------
module serial_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_cin,
  output logic             o_bit_a,
  output logic             o_bit_b,
  output logic             o_bit_c,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  // Full adder on the current bit pair and the registered carry.
  logic w_sum_bit;
  logic w_carry_next;
  logic w_last;

  assign w_sum_bit    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_next = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last       = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_op_a;
            r_b     <= i_op_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          // A low enable freezes the whole datapath; busy stays asserted.
          if (i_en) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_carry_next;
            // Sum bits enter at the MSB so the LSB lands at bit 0 after
            // WIDTH steps.
            r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
            if (w_last) begin
              r_cout  <= w_carry_next;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        S_DONE: begin
          // Leaves unconditionally; a start seen here is not queued.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          // Unused encoding 2'b11 recovers to IDLE.
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Bit taps are gated by the registered busy flag so they read 0 outside
  // RUN and never depend on any input.
  assign o_bit_a = r_busy & r_a[0];
  assign o_bit_b = r_busy & r_b[0];
  assign o_bit_c = r_busy & r_carry;

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_sum   = r_sum;
  assign o_cout  = r_cout;

endmodule

// File: tb/tb_serial_carry_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_carry_adder
//
// Self-checking bench for serial_carry_adder (WIDTH=8). Expected results
// come from plain integer addition; expected per-cycle bit taps come from
// the operand bits and the carry of a partial integer sum.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_carry_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic         i_en;
  logic [W-1:0] i_op_a;
  logic [W-1:0] i_op_b;
  logic         i_cin;
  logic         o_bit_a;
  logic         o_bit_b;
  logic         o_bit_c;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_cout;

  int errors = 0;
  int checks = 0;

  serial_carry_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_en    (i_en),
    .i_op_a  (i_op_a),
    .i_op_b  (i_op_b),
    .i_cin   (i_cin),
    .o_bit_a (o_bit_a),
    .o_bit_b (o_bit_b),
    .o_bit_c (o_bit_c),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sum   (o_sum),
    .o_cout  (o_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry entering bit position p of a + b + c.
  function automatic logic carry_into(input int a, input int b, input int c, input int p);
    int m;
    m = (1 << p) - 1;
    return 1'(((a & m) + (b & m) + c) >> p);
  endfunction

  // Run one addition. Inputs are driven at negedges; outputs are sampled at
  // negedges. stall_at/stall_len: hold en low for stall_len cycles once
  // stall_at bits are processed. rand_en: random enable instead.
  // inject_at: assert a spurious start (ops = 1) at that RUN cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input int stall_at, input int stall_len,
                        input bit rand_en, input int inject_at);
    logic [W:0] exp_res;
    logic       en_next;
    logic       exp_bc;
    int         n;
    int         p;
    int         stalls;
    bit         seen;
    exp_res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    i_op_a  = a;
    i_op_b  = b;
    i_cin   = c;
    i_start = 1'b1;
    i_en    = 1'b1;
    @(negedge clk);          // edge k has been sampled
    i_start = 1'b0;
    // Scramble operands to show they were captured at start.
    i_op_a  = W'($urandom);
    i_op_b  = W'($urandom);
    i_cin   = 1'($urandom);
    n = 0; p = 0; stalls = 0; seen = 0;
    while (!seen && n <= 40) begin
      if (o_done) begin
        seen = 1;
      end else begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_in_run: cycle %0d got %b expected 1", n, o_busy);
        end
        exp_bc = (p < W) ? carry_into(int'(a), int'(b), int'(c), p) : 1'b0;
        checks++;
        if ({o_bit_a, o_bit_b, o_bit_c} !== {(p < W) ? a[p % W] : 1'b0,
                                             (p < W) ? b[p % W] : 1'b0, exp_bc}) begin
          errors++;
          $display("FAIL bit_taps: cycle %0d bit %0d got %b%b%b expected %b%b%b",
                   n, p, o_bit_a, o_bit_b, o_bit_c,
                   a[p % W], b[p % W], exp_bc);
        end
        if (rand_en)
          en_next = ($urandom_range(0, 3) != 0);
        else
          en_next = !(stall_at >= 0 && p == stall_at && stalls < stall_len);
        if (n == inject_at) begin
          i_start = 1'b1;
          i_op_a  = W'(1);
          i_op_b  = W'(1);
        end else begin
          i_start = 1'b0;
        end
        i_en = en_next;
        if (en_next) p++; else stalls++;
        @(negedge clk);
        n++;
      end
    end
    i_start = 1'b0;
    i_en    = 1'b1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
    checks++;
    if (n != W + stalls) begin
      errors++;
      $display("FAIL latency: got %0d expected %0d", n, W + stalls);
    end
    checks++;
    if ({o_cout, o_sum} !== exp_res) begin
      errors++;
      $display("FAIL result: a=%h b=%h c=%b got %b/%h expected %b/%h",
               a, b, c, o_cout, o_sum, exp_res[W], exp_res[W-1:0]);
    end
    checks++;
    if ({o_busy, o_bit_a, o_bit_b, o_bit_c} !== 4'b0000) begin
      errors++;
      $display("FAIL done_cycle_idle: got busy/bits %b%b%b%b expected 0000",
               o_busy, o_bit_a, o_bit_b, o_bit_c);
    end
    @(negedge clk);
    checks++;
    if ({o_done, o_busy, o_cout, o_sum} !== {2'b00, exp_res}) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b res=%b/%h expected 0 0 %b/%h",
               o_done, o_busy, o_cout, o_sum, exp_res[W], exp_res[W-1:0]);
    end
    $display("op a=%h b=%h cin=%b -> cout=%b sum=%h latency=%0d stalls=%0d",
             a, b, c, o_cout, o_sum, n, stalls);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_en = 1'b1;
    i_op_a = '0; i_op_b = '0; i_cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_cout, o_sum, o_bit_a, o_bit_b, o_bit_c} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b cout=%b sum=%h bits=%b%b%b expected all 0",
               o_busy, o_done, o_cout, o_sum, o_bit_a, o_bit_b, o_bit_c);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_busy, o_done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", o_busy, o_done);
    end
    $display("reset checked");
  endtask

  task automatic test_basic();
    run_op(8'h5A, 8'h3C, 1'b0, -1, 0, 1'b0, -1);
    run_op(8'hFF, 8'h01, 1'b0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_hold();
    run_op(8'hFF, 8'hFF, 1'b1, -1, 0, 1'b0, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({o_done, o_busy, o_cout, o_sum} !== {2'b00, 1'b1, 8'hFF}) begin
        errors++;
        $display("FAIL hold: cycle %0d got done=%b busy=%b res=%b/%h expected 0 0 1/ff",
                 i, o_done, o_busy, o_cout, o_sum);
      end
    end
    $display("hold checked");
  endtask

  task automatic test_stall();
    run_op(8'h5A, 8'h3C, 1'b0, 4, 3, 1'b0, -1);
  endtask

  task automatic test_ignore_start();
    run_op(8'h5A, 8'h3C, 1'b0, -1, 0, 1'b0, 3);
    run_op(8'h01, 8'h01, 1'b0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_async_reset();
    i_op_a = 8'hFF; i_op_b = 8'h01; i_cin = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_cout, o_sum, o_bit_a, o_bit_b, o_bit_c} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b cout=%b sum=%h bits=%b%b%b expected all 0",
               o_busy, o_done, o_cout, o_sum, o_bit_a, o_bit_b, o_bit_c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("async reset checked");
    run_op(8'h5A, 8'h3C, 1'b0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), -1, 0, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), -1, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_stall();
    test_ignore_start();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
